// File: rtl/turn_timer_pkg.sv
// Shared encodings for the tic-tac-toe turn timer,
// reused by the game FSM and the display path.
package turn_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } tt_state_e;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  function automatic int div_bits(input int div);
    return ($clog2(div) > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/turn_timer_ctrl_prescaler.sv
// Modulo-TICK_DIV counter that marks each second boundary
// with a terminal-count flag.
module tick_prescaler
  import turn_timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  localparam int W = div_bits(TICK_DIV)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/turn_timer_ctrl.sv
// Turn-timer controller: game FSM, per-turn countdown
// and current-player register for tic-tac-toe.
module turn_timer_ctrl
  import turn_timer_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TURN_SECS = 9,
  localparam int SEC_BITS = $clog2(TURN_SECS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                move_done,
  input  logic                pause,
  input  logic                game_over,
  output logic                player,
  output logic [SEC_BITS-1:0] secs_left,
  output logic                tick,
  output logic                timeout,
  output logic                running
);

  localparam int DIV_BITS = div_bits(TICK_DIV);
  localparam logic [SEC_BITS-1:0] SECS_MAX =
    SEC_BITS'(TURN_SECS);
  localparam logic [DIV_BITS-1:0] PRE_LAST =
    DIV_BITS'(TICK_DIV - 1);

  tt_state_e state_q, state_d;

  logic                player_q, player_d;
  logic [SEC_BITS-1:0] secs_q, secs_d;
  logic                timeout_q, timeout_d;

  logic [DIV_BITS-1:0] pre_count;
  logic                pre_tc;
  logic                pre_clear;
  logic                pre_en;

  logic is_run;
  logic is_pause;
  logic ev_move;
  logic ev_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .enable  (pre_en),
    .count   (pre_count),
    .tc      (pre_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (game_over) begin
            state_d = OVER;
          end else if (!move_done && pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (game_over) begin
            state_d = OVER;
          end else if (!pause) begin
            state_d = RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Events are decoded mutually exclusive in priority order.
  always_comb begin
    is_run    = (state_q == RUN);
    is_pause  = (state_q == PAUSE);
    tick      = is_run && pre_tc && (pre_count == PRE_LAST);
    running   = is_run;
    ev_move   = !start && is_run && !game_over && move_done;
    ev_tick   = !start && is_run && !game_over
                && !move_done && !pause && tick;
    pre_clear = start || ev_move;
    pre_en    = is_run && !game_over;
  end

  always_comb begin
    player_d  = player_q;
    secs_d    = secs_q;
    timeout_d = 1'b0;
    unique case (1'b1)
      start: begin
        player_d = PLAYER_X;
        secs_d   = SECS_MAX;
      end
      ev_move: begin
        player_d = ~player_q;
        secs_d   = SECS_MAX;
      end
      ev_tick: begin
        if (secs_q != '0) begin
          secs_d = secs_q - 1'b1;
        end else begin
          timeout_d = 1'b1;
          player_d  = ~player_q;
          secs_d    = SECS_MAX;
        end
      end
      default: begin
        player_d = player_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      player_q  <= PLAYER_X;
      secs_q    <= SECS_MAX;
      timeout_q <= 1'b0;
    end else begin
      player_q  <= player_d;
      secs_q    <= secs_d;
      timeout_q <= timeout_d;
    end
  end

  assign player    = player_q;
  assign secs_left = secs_q;
  assign timeout   = timeout_q;

  logic unused_pause;
  assign unused_pause = is_pause;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Scoreboard bench for turn_timer_ctrl against a
// cycle-level behavioural model of the turn rules.
module tb_turn_timer_ctrl;

  localparam int TD = 4;
  localparam int TS = 3;
  localparam int SB = $clog2(TS + 1);

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          move_done;
  logic          pause;
  logic          game_over;
  logic          player;
  logic [SB-1:0] secs_left;
  logic          tick;
  logic          timeout;
  logic          running;

  turn_timer_ctrl #(
    .TICK_DIV  (TD),
    .TURN_SECS (TS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .move_done (move_done),
    .pause     (pause),
    .game_over (game_over),
    .player    (player),
    .secs_left (secs_left),
    .tick      (tick),
    .timeout   (timeout),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pl;
    int secs;
    int to;
    int run;
    int tk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  // Model: mode 0 idle, 1 run, 2 pause, 3 over;
  // phase = cycles elapsed in the current second.
  int m_mode  = 0;
  int m_pl    = 0;
  int m_secs  = TS;
  int m_phase = 0;
  int m_to    = 0;

  task automatic model(input bit r, st, go, md, pz);
    bit second_ends;
    second_ends = (m_mode == 1) && (m_phase == TD - 1);
    m_to = 0;
    if (!r) begin
      m_mode = 0; m_pl = 0; m_secs = TS; m_phase = 0;
    end else if (st) begin
      m_mode = 1; m_pl = 0; m_secs = TS; m_phase = 0;
    end else if (m_mode == 1) begin
      if (go) begin
        m_mode = 3;
      end else if (md) begin
        m_pl = 1 - m_pl; m_secs = TS; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % TD;
        if (pz) begin
          m_mode = 2;
        end else if (second_ends) begin
          if (m_secs > 0) begin
            m_secs = m_secs - 1;
          end else begin
            m_to = 1; m_pl = 1 - m_pl; m_secs = TS;
          end
        end
      end
    end else if (m_mode == 2) begin
      if (go) m_mode = 3;
      else if (!pz) m_mode = 1;
    end
  endtask

  task automatic drive(input bit r, st, go, md, pz);
    exp_t e;
    @(negedge clk);
    reset_n = r; start = st; game_over = go;
    move_done = md; pause = pz;
    model(r, st, go, md, pz);
    e.pl   = m_pl;
    e.secs = m_secs;
    e.to   = m_to;
    e.run  = (m_mode == 1);
    e.tk   = (m_mode == 1) && (m_phase == TD - 1);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit pz);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, pz);
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input int exp);
    checks++;
    if (act !== 8'(exp)) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("player", 8'(player), e.pl);
        chk("secs_left", 8'(secs_left), e.secs);
        chk("timeout", 8'(timeout), e.to);
        chk("running", 8'(running), e.run);
        chk("tick", 8'(tick), e.tk);
      end
    end
  end

  initial begin : stim
    bit pz;
    reset_n = 0; start = 0; move_done = 0;
    pause = 0; game_over = 0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    idle(3, 0);
    drive(1, 1, 0, 0, 0);
    idle(40, 0);
    idle(2, 0);
    drive(1, 0, 0, 1, 0);
    idle(10, 1);
    idle(12, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0);
    idle(3, 1);
    idle(3, 0);
    drive(1, 1, 0, 0, 0);
    idle(9, 0);
    drive(1, 0, 0, 0, 0);
    idle(6, 0);
    drive(0, 0, 0, 0, 0);
    idle(2, 0);
    pz = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, st, go, md;
      r  = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 59) == 0);
      go = ($urandom_range(0, 79) == 0);
      md = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 14) == 0) pz = ~pz;
      drive(r, st, go, md, pz);
    end
    done = 1;
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/turn_timer_ctrl.md
# turn_timer_ctrl

Turn-timer controller for the tic-tac-toe game. It sequences a one-second prescaler and a per-turn countdown, and owns whose turn it is (X or O). It hands the turn over on a legal move or on expiry, and freezes while paused or when the game is over. It sits between the move-validation/game-state logic and the seven-segment/LED display path.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per second tick; must be ≥ 2.
- `TURN_SECS`, default 9: seconds allowed per turn; must be ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin a new game (X to move).
- `move_done`  in  1  one-cycle pulse: current player made a legal move.
- `pause`  in  1  level: freeze the timer while high.
- `game_over`  in  1  one-cycle pulse: win or draw detected.
- `player`  out  1  current player; 0 = X, 1 = O.
- `secs_left`  out  SEC_BITS  remaining seconds in this turn; SEC_BITS = $clog2(TURN_SECS+1).
- `tick`  out  1  one-cycle pulse at each second boundary while in RUN.
- `timeout`  out  1  one-cycle pulse when a turn expires.
- `running`  out  1  high in RUN only.

## Operation
- FSM states: IDLE, RUN, PAUSE, OVER.
  - IDLE –start→ RUN.
  - RUN –pause→ PAUSE.
  - PAUSE –!pause→ RUN.
  - RUN/PAUSE –game_over→ OVER.
  - Any state –start→ RUN.
- `start` always does all of the following:
  - `player` ← 0
  - `secs_left` ← TURN_SECS
  - prescaler ← 0
- Prescaler (DIV_BITS = $clog2(TICK_DIV), minimum 1):
  - Counts 0..TICK_DIV-1 in RUN, then wraps to 0.
  - `tick` asserts on the cycle the prescaler holds TICK_DIV-1.
- Countdown on `tick`:
  - If `secs_left` > 0: `secs_left` decrements.
  - If `secs_left` == 0: the turn expires. `timeout` pulses, `player` toggles, and `secs_left` reloads to TURN_SECS. The state stays RUN.
  - A turn therefore lasts (TURN_SECS+1)·TICK_DIV cycles.
- `move_done` in RUN:
  - `player` toggles.
  - `secs_left` ← TURN_SECS.
  - Prescaler ← 0.
  - Ignored in IDLE, PAUSE and OVER.
- PAUSE freezes the prescaler, `secs_left` and `player`. `tick`, `timeout` and `running` are 0.
- OVER holds `player` and `secs_left` for display. It exits only via `start` or reset.
- Input priority, highest first: reset_n, start, game_over, move_done, pause, tick-driven update.
- Simultaneous events:
  - `move_done` with an expiring `tick`: the move wins. No `timeout`, single toggle.
  - `pause` with `tick`: enter PAUSE. The tick is discarded and no decrement occurs.
  - `game_over` with `move_done`: enter OVER. `player` is unchanged.
- Arithmetic is unsigned. `secs_left` never underflows, because the 0 case reloads. The prescaler compare is at exactly TICK_DIV-1.

## Timing
- Reset values:
  - state IDLE
  - `player` 0
  - `secs_left` TURN_SECS
  - prescaler 0
  - `tick`, `timeout` and `running` all 0
- Reset mid-game takes effect at the next edge with `reset_n` low. No pending `timeout` survives reset.
- All outputs are registered except `tick`, which is decoded from the registered prescaler and state.
- Latency from any input pulse to the state/`player`/`secs_left` update is 1 cycle.
- `timeout` is registered. It is high on the cycle after the expiring tick, coincident with the toggled `player` and reloaded `secs_left`.
- `running` is high the cycle after `start` is sampled.

## Structure
- `turn_timer_pkg` (shared constants include):
  - State encodings: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3.
  - Player encodings: PLAYER_X = 1'b0, PLAYER_O = 1'b1.
  - These are reused by the game FSM and display logic.
- Sub-module `tick_prescaler`:
  - Parameterised modulo-TICK_DIV counter with synchronous active-low reset, `clear` and `enable` inputs.
  - Outputs the count and a terminal-count flag.
  - Width is $clog2(TICK_DIV) with a floor of 1.
- The FSM, countdown and player register live in `turn_timer_ctrl`.

## Test plan
All scenarios use TICK_DIV=4 and TURN_SECS=3.
- Reset then `start`:
  - `running` is 1 next cycle, `player` 0, `secs_left` 3.
  - `tick` every 4 cycles, `secs_left` 3→2→1→0.
- No move for 16 cycles after `start`:
  - `timeout` pulses once.
  - `player` becomes 1 and `secs_left` reloads to 3 on the same cycle.
  - Countdown continues.
- `move_done` at `secs_left` 1, mid-prescaler:
  - `player` toggles and `secs_left` becomes 3.
  - The next `tick` arrives exactly 4 cycles later.
- `move_done` on the same cycle as an expiring `tick`:
  - Exactly one `player` toggle, `timeout` stays 0.
- `pause` held high 10 cycles in RUN:
  - `secs_left` and the prescaler are frozen, `running` 0, no `tick`.
  - After release, counting resumes from the frozen values.
- Lifecycle:
  - `game_over` in RUN → OVER; later `move_done` and `pause` have no effect.
  - `start` returns to RUN with X and `secs_left` 3.
  - `reset_n` low mid-RUN returns all outputs to their reset values.
